// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, write-back bypass and flush.
// Optional stall-cycle counter enabled by defining ID_EX_STALL_COUNT_EN.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [31:0]       id_instr,
    input  logic [DATA_W-1:0] id_pc_plus4,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_write_reg,
    input  logic [DATA_W-1:0] wb_write_data,
    input  logic              ex_flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_pc_plus4,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_dst,
    output logic [31:0]       stall_count
);

    localparam int CTRL_MEM_READ = 1;
    localparam int CTRL_REG_DST  = 5;

    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic [DATA_W-1:0] id_imm;
    logic              unused_opcode;

    assign id_rs         = id_instr[25:21];
    assign id_rt         = id_instr[20:16];
    assign id_rd         = id_instr[15:11];
    assign id_imm        = {{(DATA_W-16){id_instr[15]}}, id_instr[15:0]};
    assign unused_opcode = ^id_instr[31:26];

    logic              valid_q,   valid_d;
    logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
    logic [DATA_W-1:0] pc_q,      pc_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q,     imm_d;
    logic [REG_AW-1:0] rs_q,      rs_d;
    logic [REG_AW-1:0] rt_q,      rt_d;
    logic [REG_AW-1:0] dst_q,     dst_d;

    logic              ex_is_load;
    logic              dst_match;
    logic              stall_int;

    // Load-use: a load in EX whose destination feeds either source of the ID instruction.
    always_comb begin
        ex_is_load = valid_q & ctrl_q[CTRL_MEM_READ];
        dst_match  = (dst_q != '0) & ((dst_q == id_rs) | (dst_q == id_rt));
        stall_int  = ~rst & ex_is_load & id_valid & dst_match;
    end

    assign stall = stall_int;

    logic              rs_bypass;
    logic              rt_bypass;
    logic [DATA_W-1:0] rs_operand;
    logic [DATA_W-1:0] rt_operand;

    // The register file reads the old value when written in the same cycle, so patch it here.
    always_comb begin
        rs_bypass  = wb_reg_write & (wb_write_reg != '0) & (wb_write_reg == id_rs);
        rt_bypass  = wb_reg_write & (wb_write_reg != '0) & (wb_write_reg == id_rt);
        rs_operand = rs_bypass ? wb_write_data : rf_read_data1;
        rt_operand = rt_bypass ? wb_write_data : rf_read_data2;
    end

    always_comb begin
        valid_d   = 1'b0;
        ctrl_d    = '0;
        pc_d      = '0;
        rs_data_d = '0;
        rt_data_d = '0;
        imm_d     = '0;
        rs_d      = '0;
        rt_d      = '0;
        dst_d     = '0;
        if (!ex_flush && !stall_int && id_valid) begin
            valid_d   = 1'b1;
            ctrl_d    = id_ctrl;
            pc_d      = id_pc_plus4;
            rs_data_d = rs_operand;
            rt_data_d = rt_operand;
            imm_d     = id_imm;
            rs_d      = id_rs;
            rt_d      = id_rt;
            dst_d     = id_ctrl[CTRL_REG_DST] ? id_rd : id_rt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            pc_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            dst_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            pc_q      <= pc_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            dst_q     <= dst_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_ctrl     = ctrl_q;
    assign ex_pc_plus4 = pc_q;
    assign ex_rs_data  = rs_data_q;
    assign ex_rt_data  = rt_data_q;
    assign ex_imm      = imm_q;
    assign ex_rs       = rs_q;
    assign ex_rt       = rt_q;
    assign ex_dst      = dst_q;

`ifdef ID_EX_STALL_COUNT_EN
    logic [31:0] stall_count_q, stall_count_d;

    // Free-running wrap at 2^32 is intentional.
    always_comb begin
        stall_count_d = stall_count_q + {31'b0, stall_int};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, capture, immediates,
// bypass, load-use stall, flush priority, mid-operation reset and stall counter.
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic [7:0]  id_ctrl;
    logic [31:0] rf_read_data1;
    logic [31:0] rf_read_data2;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        ex_flush;
    logic        stall;
    logic        ex_valid;
    logic [7:0]  ex_ctrl;
    logic [31:0] ex_pc_plus4;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_dst;
    logic [31:0] stall_count;

    int passCount;
    int checkCount;

`ifdef ID_EX_STALL_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [31:0] ADD_8_9_10  = 32'h012A4020;
    localparam logic [31:0] LW_8_9      = 32'h8D288004;
    localparam logic [31:0] ADD_11_8_10 = 32'h010A5820;
    localparam logic [31:0] ADDI_9_7FFF = 32'h21297FFF;
    localparam logic [7:0]  CTRL_R      = 8'h21;
    localparam logic [7:0]  CTRL_LW     = 8'h1B;
    localparam logic [7:0]  CTRL_ADDI   = 8'h11;

    id_ex_stage dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .id_pc_plus4  (id_pc_plus4),
        .id_ctrl      (id_ctrl),
        .rf_read_data1(rf_read_data1),
        .rf_read_data2(rf_read_data2),
        .wb_reg_write (wb_reg_write),
        .wb_write_reg (wb_write_reg),
        .wb_write_data(wb_write_data),
        .ex_flush     (ex_flush),
        .stall        (stall),
        .ex_valid     (ex_valid),
        .ex_ctrl      (ex_ctrl),
        .ex_pc_plus4  (ex_pc_plus4),
        .ex_rs_data   (ex_rs_data),
        .ex_rt_data   (ex_rt_data),
        .ex_imm       (ex_imm),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_dst       (ex_dst),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [7:0] ctrl,
                                 input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2);
        id_valid      = v;
        id_instr      = instr;
        id_ctrl       = ctrl;
        id_pc_plus4   = pc;
        rf_read_data1 = d1;
        rf_read_data2 = d2;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        passCount     = 0;
        checkCount    = 0;
        rst           = 1'b1;
        ex_flush      = 1'b0;
        wb_reg_write  = 1'b0;
        wb_write_reg  = 5'd0;
        wb_write_data = 32'h0;
        applyStimulus(1'b1, ADD_8_9_10, CTRL_R, 32'h104, 32'h11, 32'h22);

        // Reset held two cycles with a valid instruction presented.
        step();
        step();
        checkOutput("rst_valid", {31'b0, ex_valid}, 32'd0);
        checkOutput("rst_ctrl", {24'b0, ex_ctrl}, 32'd0);
        checkOutput("rst_pc", ex_pc_plus4, 32'd0);
        checkOutput("rst_rs_data", ex_rs_data, 32'd0);
        checkOutput("rst_dst", {27'b0, ex_dst}, 32'd0);
        checkOutput("rst_imm", ex_imm, 32'd0);
        checkOutput("rst_stall", {31'b0, stall}, 32'd0);
        checkOutput("rst_count", stall_count, 32'd0);

        // First capture: add $8,$9,$10.
        rst = 1'b0;
        step();
        checkOutput("add_valid", {31'b0, ex_valid}, 32'd1);
        checkOutput("add_rs", {27'b0, ex_rs}, 32'd9);
        checkOutput("add_rt", {27'b0, ex_rt}, 32'd10);
        checkOutput("add_dst", {27'b0, ex_dst}, 32'd8);
        checkOutput("add_ctrl", {24'b0, ex_ctrl}, 32'h21);
        checkOutput("add_pc", ex_pc_plus4, 32'h104);
        checkOutput("add_rs_data", ex_rs_data, 32'h11);
        checkOutput("add_rt_data", ex_rt_data, 32'h22);
        checkOutput("add_imm", ex_imm, 32'h00004020);

        // Load with negative immediate; destination is rt=8.
        applyStimulus(1'b1, LW_8_9, CTRL_LW, 32'h108, 32'h33, 32'h44);
        step();
        checkOutput("lw_imm_neg", ex_imm, 32'hFFFF8004);
        checkOutput("lw_dst", {27'b0, ex_dst}, 32'd8);
        checkOutput("lw_ctrl", {24'b0, ex_ctrl}, 32'h1B);

        // Dependent add $11,$8,$10 must stall exactly one cycle.
        applyStimulus(1'b1, ADD_11_8_10, CTRL_R, 32'h10C, 32'h55, 32'h66);
        checkOutput("lu_stall", {31'b0, stall}, 32'd1);
        step();
        checkOutput("lu_bubble_valid", {31'b0, ex_valid}, 32'd0);
        checkOutput("lu_bubble_ctrl", {24'b0, ex_ctrl}, 32'd0);
        checkOutput("lu_bubble_dst", {27'b0, ex_dst}, 32'd0);
        checkOutput("lu_stall_drop", {31'b0, stall}, 32'd0);
        step();
        checkOutput("lu_capture_valid", {31'b0, ex_valid}, 32'd1);
        checkOutput("lu_capture_rs", {27'b0, ex_rs}, 32'd8);
        checkOutput("lu_capture_dst", {27'b0, ex_dst}, 32'd11);
        checkOutput("lu_count", stall_count, CNT_EN ? 32'd1 : 32'd0);

        // Positive immediate upper bound.
        applyStimulus(1'b1, ADDI_9_7FFF, CTRL_ADDI, 32'h110, 32'h77, 32'h88);
        checkOutput("addi_no_stall", {31'b0, stall}, 32'd0);
        step();
        checkOutput("imm_pos", ex_imm, 32'h00007FFF);
        checkOutput("addi_dst", {27'b0, ex_dst}, 32'd9);

        // Write-back bypass on rs, then register 0, then rt, then write disabled.
        applyStimulus(1'b1, ADD_8_9_10, CTRL_R, 32'h114, 32'd9, 32'h22);
        wb_reg_write  = 1'b1;
        wb_write_reg  = 5'd9;
        wb_write_data = 32'hDEADBEEF;
        step();
        checkOutput("byp_rs", ex_rs_data, 32'hDEADBEEF);
        checkOutput("byp_rt_untouched", ex_rt_data, 32'h22);
        wb_write_reg = 5'd0;
        step();
        checkOutput("byp_reg0", ex_rs_data, 32'd9);
        wb_write_reg = 5'd10;
        step();
        checkOutput("byp_rt", ex_rt_data, 32'hDEADBEEF);
        checkOutput("byp_rs_untouched", ex_rs_data, 32'd9);
        wb_write_reg = 5'd9;
        wb_reg_write = 1'b0;
        step();
        checkOutput("byp_disabled", ex_rs_data, 32'd9);

        // Flush while a load-use stall is active.
        applyStimulus(1'b1, LW_8_9, CTRL_LW, 32'h118, 32'h0, 32'h0);
        step();
        applyStimulus(1'b1, ADD_11_8_10, CTRL_R, 32'h11C, 32'h55, 32'h66);
        ex_flush = 1'b1;
        #1;
        checkOutput("flush_stall_out", {31'b0, stall}, 32'd1);
        step();
        checkOutput("flush_valid", {31'b0, ex_valid}, 32'd0);
        checkOutput("flush_ctrl", {24'b0, ex_ctrl}, 32'd0);
        ex_flush = 1'b0;
        step();
        checkOutput("post_flush_valid", {31'b0, ex_valid}, 32'd1);
        checkOutput("flush_count", stall_count, CNT_EN ? 32'd2 : 32'd0);

        // id_valid low produces a bubble.
        applyStimulus(1'b0, ADD_8_9_10, CTRL_R, 32'h120, 32'h1, 32'h2);
        step();
        checkOutput("idle_valid", {31'b0, ex_valid}, 32'd0);
        checkOutput("idle_rs", {27'b0, ex_rs}, 32'd0);

        // Third load-use stall.
        applyStimulus(1'b1, LW_8_9, CTRL_LW, 32'h124, 32'h0, 32'h0);
        step();
        applyStimulus(1'b1, ADD_11_8_10, CTRL_R, 32'h128, 32'h55, 32'h66);
        checkOutput("lu3_stall", {31'b0, stall}, 32'd1);
        step();
        step();
        checkOutput("lu3_count", stall_count, CNT_EN ? 32'd3 : 32'd0);

        // Mid-operation reset while a stall condition is present.
        applyStimulus(1'b1, LW_8_9, CTRL_LW, 32'h12C, 32'h0, 32'h0);
        step();
        applyStimulus(1'b1, ADD_11_8_10, CTRL_R, 32'h130, 32'h55, 32'h66);
        checkOutput("mid_stall_pre", {31'b0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid_stall_rst", {31'b0, stall}, 32'd0);
        step();
        checkOutput("mid_valid", {31'b0, ex_valid}, 32'd0);
        checkOutput("mid_dst", {27'b0, ex_dst}, 32'd0);
        checkOutput("mid_count", stall_count, 32'd0);
        rst = 1'b0;
        step();
        checkOutput("after_rst_capture", {31'b0, ex_valid}, 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
